pea_invoke_scheduler: RTL and testbench

//  Multi-channel invoke controller for the PEA. It arbitrates NUM_CH independent PEA firing FSMs.

---
 rtl/pea_invoke_scheduler_pkg.sv | 24 ++
 rtl/pea_invoke_scheduler_arbiter.sv | 35 +++
 rtl/pea_invoke_scheduler.sv | 175 +++++++++++++++++
 tb/tb_pea_invoke_scheduler.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pea_invoke_scheduler_pkg.sv
// Shared definitions for the PEA invoke scheduler.
//   pea_state_e : controller state encoding (3 bits)
//   WD_W        : watchdog counter width (covers TIMEOUT up to 65535)
//   ch_width()  : channel-index width, ceil(log2(n)) with a minimum of 1
package pea_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_ABORT = 3'd4
  } pea_state_e;

  localparam int unsigned WD_W = 16;

  function automatic int unsigned ch_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/pea_invoke_scheduler_arbiter.sv
// Round-robin channel picker (purely combinational).
//   ready_i       : per-channel ready vector
//   rr_ptr_i      : channel to search from first
//   grant_o       : first ready channel at or after rr_ptr_i, with wrap
//   grant_valid_o : 1 when any channel is ready
module pea_rr_arbiter #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CH_W   = 1
) (
  input  logic [NUM_CH-1:0] ready_i,
  input  logic [CH_W-1:0]   rr_ptr_i,
  output logic [CH_W-1:0]   grant_o,
  output logic              grant_valid_o
);

  int unsigned       idx;
  logic [CH_W-1:0]   idx_w;

  always_comb begin
    grant_o       = '0;
    grant_valid_o = 1'b0;
    idx           = 0;
    idx_w         = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = 32'(rr_ptr_i) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      idx_w = CH_W'(idx);
      if (!grant_valid_o && ready_i[idx_w]) begin
        grant_o       = idx_w;
        grant_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pea_invoke_scheduler.sv
// Multi-channel PEA invoke controller: starts one firing at a time in
// round-robin order and aborts firings that exceed the watchdog limit.
//   clk, rst (async, active low), soft_clr (sync clear, highest priority)
//   invoke/command_pop/out_free : per-channel request and FIFO status
//   done_fsm                    : per-channel completion pulse
//   start_fsm/abort_fsm         : one-hot pulses to the granted channel
//   FC                          : granted firing completed normally
//   busy, grant_id              : activity and current/last grant
//   fire_cnt/abort_cnt          : saturating event counters
//   err_sticky                  : per-channel timeout history
module pea_invoke_scheduler
  import pea_pkg::*;
#(
  parameter  int unsigned NUM_CH    = 2,
  parameter  int unsigned word_size = 16,
  parameter  int unsigned TIMEOUT   = 255,
  parameter  int unsigned CNT_W     = 16,
  localparam int unsigned CH_W      = ch_width(NUM_CH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        soft_clr,
  input  logic [NUM_CH-1:0]           invoke,
  input  logic [NUM_CH*word_size-1:0] command_pop,
  input  logic [NUM_CH*word_size-1:0] out_free,
  input  logic [NUM_CH-1:0]           done_fsm,
  output logic [NUM_CH-1:0]           start_fsm,
  output logic [NUM_CH-1:0]           abort_fsm,
  output logic                        FC,
  output logic                        busy,
  output logic [CH_W-1:0]             grant_id,
  output logic [CNT_W-1:0]            fire_cnt,
  output logic [CNT_W-1:0]            abort_cnt,
  output logic [NUM_CH-1:0]           err_sticky
);

  // Free-word compare is done at least 2 bits wide so a 1-bit population
  // can never alias the threshold.
  localparam int unsigned FW = (word_size > 2) ? word_size : 2;

  pea_state_e         state_q, state_d;
  logic [CH_W-1:0]    grant_q, grant_d;
  logic [CH_W-1:0]    rr_q, rr_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic               fc_q, fc_d;
  logic [CNT_W-1:0]   fire_q, fire_d;
  logic [CNT_W-1:0]   abort_q, abort_d;
  logic [NUM_CH-1:0]  err_q, err_d;

  logic [NUM_CH-1:0]  ready;
  logic [FW-1:0]      free_w;
  logic [NUM_CH-1:0]  gnt_oh;
  logic [CH_W-1:0]    arb_grant;
  logic               arb_valid;
  logic               done_g;

  always_comb begin
    ready  = '0;
    free_w = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      free_w   = FW'(out_free[i*word_size +: word_size]);
      ready[i] = invoke[i] && (command_pop[i*word_size +: word_size] != '0)
                 && (free_w >= FW'(2));
    end
  end

  always_comb begin
    gnt_oh = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      gnt_oh[i] = (grant_q == CH_W'(i));
    end
  end

  assign done_g = |(done_fsm & gnt_oh);

  pea_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .ready_i       (ready),
    .rr_ptr_i      (rr_q),
    .grant_o       (arb_grant),
    .grant_valid_o (arb_valid)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    wd_d      = wd_q;
    fc_d      = 1'b0;
    fire_d    = fire_q;
    abort_d   = abort_q;
    err_d     = err_q;
    start_fsm = '0;
    abort_fsm = '0;
    case (state_q)
      S_IDLE: begin
        if (|ready) state_d = S_ARB;
      end
      S_ARB: begin
        if (arb_valid) begin
          grant_d = arb_grant;
          rr_d    = (arb_grant == CH_W'(NUM_CH - 1)) ? '0 : arb_grant + CH_W'(1);
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        start_fsm = gnt_oh;
        wd_d      = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        // Completion is tested first so a done on the expiry cycle wins.
        if (done_g) begin
          fc_d    = 1'b1;
          fire_d  = (fire_q == '1) ? fire_q : fire_q + CNT_W'(1);
          state_d = S_IDLE;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          state_d = S_ABORT;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_ABORT: begin
        abort_fsm = gnt_oh;
        err_d     = err_q | gnt_oh;
        abort_d   = (abort_q == '1) ? abort_q : abort_q + CNT_W'(1);
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      wd_q    <= '0;
      fc_q    <= 1'b0;
      fire_q  <= '0;
      abort_q <= '0;
      err_q   <= '0;
    end else if (soft_clr) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      wd_q    <= '0;
      fc_q    <= 1'b0;
      fire_q  <= '0;
      abort_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      wd_q    <= wd_d;
      fc_q    <= fc_d;
      fire_q  <= fire_d;
      abort_q <= abort_d;
      err_q   <= err_d;
    end
  end

  assign FC         = fc_q;
  assign busy       = (state_q != S_IDLE);
  assign grant_id   = grant_q;
  assign fire_cnt   = fire_q;
  assign abort_cnt  = abort_q;
  assign err_sticky = err_q;

endmodule

// File: tb/tb_pea_invoke_scheduler.sv
// Bench for pea_invoke_scheduler: two instances (wide and 2-bit counters)
// share one stimulus; a cycle-age model predicts every output each cycle.
module tb_pea_invoke_scheduler;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        soft_clr = 1'b0;
  logic [1:0]  inv = 2'b00;
  int          pop [2];
  int          fre [2];
  logic [1:0]  done_fsm = 2'b00;
  logic [31:0] cmd_v, free_v;

  logic [1:0]  start_a, abort_a, err_a, start_b, abort_b, err_b;
  logic        fc_a, busy_a, fc_b, busy_b;
  logic [0:0]  gid_a, gid_b;
  logic [15:0] fire_a, acnt_a;
  logic [1:0]  fire_b, acnt_b;

  assign cmd_v  = {16'(pop[1]), 16'(pop[0])};
  assign free_v = {16'(fre[1]), 16'(fre[0])};

  always #5 clk = ~clk;

  pea_invoke_scheduler #(.NUM_CH(2), .word_size(16), .TIMEOUT(TO), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst_n), .soft_clr(soft_clr), .invoke(inv),
    .command_pop(cmd_v), .out_free(free_v), .done_fsm(done_fsm),
    .start_fsm(start_a), .abort_fsm(abort_a), .FC(fc_a), .busy(busy_a),
    .grant_id(gid_a), .fire_cnt(fire_a), .abort_cnt(acnt_a), .err_sticky(err_a));

  pea_invoke_scheduler #(.NUM_CH(2), .word_size(16), .TIMEOUT(TO), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst_n), .soft_clr(soft_clr), .invoke(inv),
    .command_pop(cmd_v), .out_free(free_v), .done_fsm(done_fsm),
    .start_fsm(start_b), .abort_fsm(abort_b), .FC(fc_b), .busy(busy_b),
    .grant_id(gid_b), .fire_cnt(fire_b), .abort_cnt(acnt_b), .err_sticky(err_b));

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  // ---------------- behavioural model ----------------
  // A firing is tracked by its age in cycles since the start pulse (age 0).
  // Done is honoured at ages 1..TO; age TO+1 is the abort pulse.
  bit       m_pend, m_act, m_fc;
  int       m_age, m_grant, m_rr, m_fire, m_abort;
  bit [1:0] m_err;

  function automatic bit rdy(input int i);
    return inv[i] && (pop[i] != 0) && (fre[i] >= 2);
  endfunction

  task automatic model_clear();
    m_pend = 0; m_act = 0; m_fc = 0; m_age = 0; m_grant = 0; m_rr = 0;
    m_fire = 0; m_abort = 0; m_err = '0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || soft_clr) begin
      model_clear();
    end else begin
      m_fc = 0;
      if (m_act) begin
        if (m_age >= 1 && m_age <= TO && done_fsm[m_grant]) begin
          m_fc = 1; m_fire++; m_act = 0;
        end else if (m_age == TO + 1) begin
          m_err[m_grant] = 1'b1; m_abort++; m_act = 0;
        end else begin
          m_age++;
        end
      end else if (m_pend) begin
        m_pend = 0;
        for (int k = 0; k < 2; k++) begin
          int c;
          c = (m_rr + k) % 2;
          if (!m_act && rdy(c)) begin
            m_grant = c; m_rr = (c + 1) % 2; m_act = 1; m_age = 0;
          end
        end
      end else if (rdy(0) || rdy(1)) begin
        m_pend = 1;
      end
    end
  end

  // ---------------- firing responder ----------------
  // dly = cycles into WAIT before done (-1: never); noise drives other channels.
  int       dly = -1;
  logic [1:0] noise = 2'b00;
  bit       r_act;
  int       r_cnt, r_ch;

  always @(negedge clk) begin
    done_fsm = noise;
    if (!rst_n) begin
      r_act = 0;
    end else begin
      if (r_act) begin
        if (r_cnt == 0) begin
          done_fsm[r_ch] = 1'b1;
          r_act = 0;
        end else begin
          r_cnt--;
        end
      end
      if (start_a != 2'b00 && dly >= 0) begin
        r_act = 1; r_cnt = dly; r_ch = start_a[1] ? 1 : 0;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  int g_ch [8];
  int g_cyc [8];

  task automatic wait_starts(input int n, input int budget);
    int seen, c;
    seen = 0; c = 0;
    while (seen < n && c < budget) begin
      @(negedge clk);
      c++;
      if (start_a != 2'b00) begin
        g_ch[seen] = start_a[1] ? 1 : 0;
        g_cyc[seen] = cyc;
        seen++;
        if (seen == n) inv = 2'b00;
      end
    end
    if (seen < n) chk("start_wait_expired", seen, n);
  endtask

  task automatic wait_idle(input int budget, output int aborts);
    int c;
    c = 0; aborts = 0;
    do begin
      @(negedge clk);
      c++;
      if (abort_a != 2'b00) aborts++;
    end while (busy_a && c < budget);
    if (busy_a) chk("idle_wait_expired", busy_a, 0);
  endtask

  int ab, c, nst;

  initial begin
    pop[0] = 0; pop[1] = 0; fre[0] = 0; fre[1] = 0;

    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          chk("start_a", start_a, (m_act && m_age == 0) ? (1 << m_grant) : 0);
          chk("abort_a", abort_a, (m_act && m_age == TO + 1) ? (1 << m_grant) : 0);
          chk("start_b", start_b, (m_act && m_age == 0) ? (1 << m_grant) : 0);
          chk("abort_b", abort_b, (m_act && m_age == TO + 1) ? (1 << m_grant) : 0);
          chk("busy_a", busy_a, m_pend || m_act);
          chk("busy_b", busy_b, m_pend || m_act);
          chk("fc_a", fc_a, m_fc);
          chk("fc_b", fc_b, m_fc);
          chk("grant_a", gid_a, m_grant);
          chk("grant_b", gid_b, m_grant);
          chk("fire_a", fire_a, (m_fire > 65535) ? 65535 : m_fire);
          chk("fire_b", fire_b, (m_fire > 3) ? 3 : m_fire);
          chk("abort_cnt_a", acnt_a, m_abort);
          chk("abort_cnt_b", acnt_b, (m_abort > 3) ? 3 : m_abort);
          chk("err_a", err_a, m_err);
          chk("err_b", err_b, m_err);
        end
      end
    join_none

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_busy", busy_a, 0);
    chk("rst_fire", fire_a, 0);
    chk("rst_err", err_a, 0);

    // single channel, done at WAIT+5, done on the other channel ignored
    noise = 2'b10; dly = 5;
    pop[0] = 3; fre[0] = 10; inv = 2'b01;
    @(negedge clk); @(negedge clk);
    chk("t2_start_lat", start_a, 2'b01);
    inv = 2'b00;
    c = 0;
    do begin @(negedge clk); c++; end while (!fc_a && c < 20);
    chk("t2_fc_delay", c, 7);
    wait_idle(20, ab);
    chk("t2_fire_cnt", fire_a, 1);
    noise = 2'b00;

    // round robin after soft clear
    @(negedge clk); soft_clr = 1'b1;
    @(negedge clk); soft_clr = 1'b0;
    chk("t3_clr_fire", fire_a, 0);
    dly = 3; pop[1] = 3; fre[1] = 10; inv = 2'b11;
    wait_starts(4, 100);
    for (int k = 0; k < 4; k++) chk("t3_grant_order", g_ch[k], k % 2);
    wait_idle(30, ab);
    chk("t3_fire_cnt", fire_a, 4);
    chk("t3_fire_sat_b", fire_b, 3);

    // not ready: empty command FIFO, then too little output space
    dly = 2; pop[1] = 0; pop[0] = 0; fre[0] = 10; inv = 2'b01;
    nst = 0;
    repeat (10) begin @(negedge clk); if (start_a != 0 || busy_a) nst++; end
    chk("t4_pop0_zero", nst, 0);
    pop[0] = 3; fre[0] = 1; nst = 0;
    repeat (10) begin @(negedge clk); if (start_a != 0 || busy_a) nst++; end
    chk("t4_free0_one", nst, 0);
    fre[0] = 2;
    wait_starts(1, 10);
    wait_idle(30, ab);
    chk("t4_free0_two_fire", fire_a, 5);

    // timeout on channel 1
    dly = -1; pop[1] = 3; fre[1] = 10; inv = 2'b10;
    wait_starts(1, 10);
    c = 0;
    do begin @(negedge clk); c++; end while (abort_a == 2'b00 && c < 20);
    chk("t5_abort_delay", c, TO + 1);
    chk("t5_abort_ch", abort_a, 2'b10);
    @(negedge clk);
    chk("t5_err", err_a, 2'b10);
    chk("t5_abort_cnt", acnt_a, 1);
    // done on the expiry cycle completes normally
    dly = TO - 1; inv = 2'b01;
    wait_starts(1, 10);
    wait_idle(30, ab);
    chk("t5_edge_no_abort", ab, 0);
    chk("t5_edge_abort_cnt", acnt_a, 1);
    chk("t5_edge_fire", fire_a, 6);

    // asynchronous reset while waiting
    dly = -1; inv = 2'b01;
    wait_starts(1, 10);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_busy", busy_a, 0);
    chk("t1_start", start_a, 0);
    chk("t1_abort", abort_a, 0);
    chk("t1_fire", fire_a, 0);
    chk("t1_abort_cnt", acnt_a, 0);
    chk("t1_err", err_a, 0);
    inv = 2'b00;
    @(negedge clk); rst_n = 1'b1;

    // back-to-back firings, saturation, soft clear priority
    dly = 0; inv = 2'b01;
    wait_starts(5, 100);
    for (int k = 1; k < 5; k++) chk("t6_start_gap", g_cyc[k] - g_cyc[k-1], 4);
    wait_idle(20, ab);
    chk("t6_fire_a", fire_a, 5);
    chk("t6_fire_b_sat", fire_b, 3);
    dly = -1; inv = 2'b10;
    wait_starts(1, 10);
    wait_idle(30, ab);
    chk("t6_err_set", err_a, 2'b10);
    soft_clr = 1'b1; inv = 2'b01;
    @(negedge clk);
    chk("t6_clr_busy", busy_a, 0);
    chk("t6_clr_fire_a", fire_a, 0);
    chk("t6_clr_fire_b", fire_b, 0);
    chk("t6_clr_abort", acnt_a, 0);
    chk("t6_clr_err", err_a, 0);
    soft_clr = 1'b0; inv = 2'b00;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: got no completion, expected summary");
    $fatal(1, "time limit");
  end

endmodule
